// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and output decode for the PLL bring-up sequencer
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_state_e;

    typedef struct packed {
        logic resetb;
        logic bypass;
        logic clk_en;
        logic ready;
        logic fault;
    } pll_outs_t;

    // Moore output table: each state fully determines the PLL pins and status flags
    function automatic pll_outs_t decode_outs(input pll_state_e s);
        pll_outs_t o;
        o = '0;
        case (s)
            ST_WAIT_LOCK: o.resetb = 1'b1;
            ST_SETTLE:    o.resetb = 1'b1;
            ST_RUN: begin
                o.resetb = 1'b1;
                o.clk_en = 1'b1;
                o.ready  = 1'b1;
            end
            ST_FAULT: begin
                o.bypass = 1'b1;
                o.clk_en = 1'b1;
                o.fault  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives the rest of the design a clean level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_seq_ctrl.sv
// rtl/pll_seq_ctrl.sv - PLL reset/lock/settle sequencer with bounded retries and bypass fallback
module pll_seq_ctrl
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int SETTLE_CYCLES = 480,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pll_lock,
    output logic               pll_resetb,
    output logic               pll_bypass,
    output logic               clk_en,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retries,
    output logic [STATE_W-1:0] state
);

    localparam int MAX_CNT_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT   = (MAX_CNT_A > SETTLE_CYCLES) ? MAX_CNT_A : SETTLE_CYCLES;

    // Parameter sanity is enforced at elaboration so a bad build never produces silicon
    if (CNT_W < $clog2(MAX_CNT + 1)) begin : g_cnt_w_too_small
        $error("pll_seq_ctrl: CNT_W cannot hold the largest cycle count");
    end
    if (RESET_CYCLES < 1 || SETTLE_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_cycles
        $error("pll_seq_ctrl: RESET_CYCLES, SETTLE_CYCLES and LOCK_TIMEOUT must be >= 1");
    end
    if (MAX_RETRIES < 0 || MAX_RETRIES >= (1 << RETRY_W)) begin : g_bad_retries
        $error("pll_seq_ctrl: MAX_RETRIES does not fit the retries port");
    end

    localparam logic [CNT_W-1:0]   RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    pll_outs_t          outs_q;
    logic               lock_s;
    logic               fail;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // State, counters and registered Moore outputs (outputs decoded from the next state)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            scnt_q    <= '0;
            retries_q <= '0;
            outs_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            scnt_q    <= scnt_d;
            retries_q <= retries_d;
            outs_q    <= decode_outs(state_d);
        end
    end

    // Next-state logic; precedence is start-low, then settle done, then timeout, then lock drop
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        scnt_d    = scnt_q;
        retries_d = retries_q;
        fail      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RESET;
            end
            ST_RESET: begin
                if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
                else                     cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_WAIT_LOCK: begin
                tcnt_d = tcnt_q + CNT_W'(1);
                if (lock_s)                 state_d = ST_SETTLE;
                else if (tcnt_q >= TIMEO_LAST) fail = 1'b1;
            end
            ST_SETTLE: begin
                tcnt_d = tcnt_q + CNT_W'(1);
                if (lock_s && scnt_q == SETTLE_LAST) state_d = ST_RUN;
                else if (tcnt_q >= TIMEO_LAST)       fail    = 1'b1;
                else if (!lock_s)                    state_d = ST_WAIT_LOCK;
                else                                 scnt_d  = scnt_q + CNT_W'(1);
            end
            ST_RUN: begin
                if (!lock_s) fail = 1'b1;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        if (fail) begin
            if (retries_q == RETRY_MAX) begin
                state_d = ST_FAULT;
            end else begin
                retries_d = retries_q + RETRY_W'(1);
                state_d   = ST_RESET;
            end
        end

        if (!start) begin
            state_d   = ST_IDLE;
            retries_d = '0;
        end

        // Each counter only lives inside its own phase and restarts from zero on the next entry
        if (state_d != ST_RESET || state_q != ST_RESET) cnt_d = '0;
        if (state_d != ST_WAIT_LOCK && state_d != ST_SETTLE) tcnt_d = '0;
        if (state_d != ST_SETTLE || state_q != ST_SETTLE) scnt_d = '0;
    end

    assign pll_resetb = outs_q.resetb;
    assign pll_bypass = outs_q.bypass;
    assign clk_en     = outs_q.clk_en;
    assign ready      = outs_q.ready;
    assign fault      = outs_q.fault;
    assign retries    = retries_q;
    assign state      = state_q;

endmodule

// File: doc/pll_seq_ctrl.md
Name: pll_seq_ctrl

Overview:
Sequences bring-up and supervision of the SB_PLL40_CORE fed by the 48 MHz SB_HFOSC. It holds the PLL in reset, releases it, waits for lock within a timeout, and requires lock to stay stable before enabling downstream logic. On timeout or loss of lock it retries a bounded number of times, then falls back to PLL bypass and flags a fault. Runs on the always-present reference clock and sits between the oscillator/PLL primitives and the user clock-enable logic (LED counters etc.).

Parameters:
RESET_CYCLES, 16, cycles pll_resetb is held low per attempt (≥1)
LOCK_TIMEOUT, 4800, max cycles in WAIT_LOCK+SETTLE per attempt (100 us at 48 MHz)
SETTLE_CYCLES, 480, consecutive synced-lock-high cycles required before RUN (≥1)
MAX_RETRIES, 3, retries after first attempt before FAULT (total attempts = MAX_RETRIES+1)
CNT_W, 16, width of the cycle counter; must hold max(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)

Ports:
clk  in  1  reference clock (clk_48mhz from HFOSC); never the PLL output
rst  in  1  asynchronous, active-high reset
start  in  1  level; high requests PLL operation, low returns to IDLE
pll_lock  in  1  PLL LOCK output, asynchronous to clk
pll_resetb  out  1  to PLL RESETB (active low)
pll_bypass  out  1  to PLL BYPASS
clk_en  out  1  downstream clock enable / release
ready  out  1  PLL locked and stable (RUN)
fault  out  1  retries exhausted, running in bypass
retries  out  2  failures counted in the current sequence (saturates at MAX_RETRIES)
state  out  3  encoded FSM state, debug

Behaviour:
- Clock is one clock; reset is asynchronous and active-high. All outputs registered, decoded from the state register (Moore).
- Reset values: pll_resetb=0, pll_bypass=0, clk_en=0, ready=0, fault=0, retries=0, state=IDLE, counters=0, synchronizer flops=0.
- pll_lock passes through a 2-flop synchronizer → lock_s; 2-cycle latency, no other filtering.
- States and outputs (resetb/bypass/clk_en/ready/fault):
  IDLE 0/0/0/0/0; RESET 0/0/0/0/0; WAIT_LOCK 1/0/0/0/0; SETTLE 1/0/0/0/0; RUN 1/0/1/1/0; FAULT 0/1/1/0/1.
- start low in any state → IDLE next cycle; retries cleared on IDLE entry. This is the only exit from FAULT.
- IDLE: start high → RESET, cnt=0.
- RESET: cnt counts; after RESET_CYCLES cycles in RESET → WAIT_LOCK, timeout counter tcnt=0.
- WAIT_LOCK: tcnt increments each cycle; lock_s high → SETTLE, scnt=0; tcnt reaching LOCK_TIMEOUT with lock_s low → failure event.
- SETTLE: tcnt keeps incrementing (not reset); scnt increments while lock_s high; lock_s low → WAIT_LOCK, scnt=0, no retry charged; scnt reaching SETTLE_CYCLES → RUN; tcnt reaching LOCK_TIMEOUT first → failure event. If both complete in the same cycle, RUN wins.
- RUN: lock_s low → failure event (clk_en drops the cycle after, i.e. 3 cycles after pll_lock falls).
- Failure event: if retries==MAX_RETRIES → FAULT; else retries+1 and → RESET, cnt=0.
- start low in the same cycle as a failure event: IDLE wins.
- Counters never wrap: each stops/clears on state exit. CNT_W too small is a parameter error (elaboration assertion).
- pll_lock toggling during IDLE/RESET/FAULT is ignored.

Decomposition:
- pll_seq_pkg: state enum (IDLE=0, RESET=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5), STATE_W=3, RETRY_W=2.
- Sub-module sync_2ff (1-bit two-flop synchronizer, async-rst to 0) for pll_lock; reusable elsewhere.

Test Plan:
(Bench params: RESET_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=5, MAX_RETRIES=2.)
- Nominal: start=1, pll_lock rises 6 cycles after pll_resetb rises and stays high → pll_resetb low exactly 4 cycles, SETTLE entered 3 cycles after pll_lock rises, RUN/clk_en=1/ready=1 5 cycles later, retries=0.
- Lock never rises: start=1 → three attempts (4 low + 20 wait each), retries 0→1→2, then FAULT with pll_bypass=1, clk_en=1, fault=1, pll_resetb=0; start=0 → IDLE with all outputs 0.
- Settle glitch: lock high 3 cycles, low 1, then high → returns to WAIT_LOCK, retries unchanged, reaches RUN if the 5-cycle window completes before tcnt=20.
- Lock loss in RUN: drop pll_lock → clk_en=0 3 cycles later, retries=1, new RESET phase; relock → RUN.
- Async reset mid-SETTLE: rst pulse asynchronous to clk → all outputs to reset values immediately; after release with start=1, full sequence restarts from RESET.
- start dropped in WAIT_LOCK at tcnt=10 → IDLE next cycle, pll_resetb=0, retries=0.
